// File: rtl/fetch_if.sv
// Fetch-stage bus: write-back PC load, instruction-memory read handshake,
// and the decode-side valid/ack handshake, plus status flags.
interface fetch_if;
  logic [31:0] pc_wd_i;
  logic        pc_load_i;
  logic [31:0] mem_addr_o;
  logic        mem_rd_o;
  logic        mem_ready_i;
  logic [31:0] mem_data_i;
  logic [31:0] ir_o;
  logic [31:0] pc_o;
  logic        ir_valid_o;
  logic        ir_ack_i;
  logic        busy_o;
  logic        fault_o;

  // The fetch unit itself.
  modport master (
    input  pc_wd_i, pc_load_i, mem_ready_i, mem_data_i, ir_ack_i,
    output mem_addr_o, mem_rd_o, ir_o, pc_o, ir_valid_o, busy_o, fault_o
  );

  // Write-back, memory and decode as seen from outside the fetch unit.
  modport slave (
    output pc_wd_i, pc_load_i, mem_ready_i, mem_data_i, ir_ack_i,
    input  mem_addr_o, mem_rd_o, ir_o, pc_o, ir_valid_o, busy_o, fault_o
  );
endinterface

// File: rtl/fetch.sv
// Instruction-fetch reader: one outstanding memory read, a one-entry pending-PC
// slot for loads that arrive mid-fetch, and a sticky fault state for bad PCs/time-outs.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic    clk,
  input  logic    reset,
  fetch_if.master bus
);

  localparam int unsigned TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} state_e;

  state_e        state_q,    state_d;
  logic [31:0]   addr_q,     addr_d;
  logic          pend_q,     pend_d;
  logic [31:0]   pend_pc_q,  pend_pc_d;
  logic [TW-1:0] tmo_cnt_q,  tmo_cnt_d;
  logic [31:0]   ir_q,       ir_d;
  logic [31:0]   pc_q,       pc_d;
  logic          ir_valid_q, ir_valid_d;
  logic          fault_q,    fault_d;

  logic misaligned;
  assign misaligned = (addr_q[1:0] != 2'b00);

  // While reset is held the request is masked so memory never sees a read
  // for a fetch that is about to be restarted.
  assign bus.mem_addr_o = addr_q;
  assign bus.mem_rd_o   = (state_q == REQ) & ~misaligned & ~reset;
  assign bus.busy_o     = (state_q == REQ) & ~reset;
  assign bus.ir_o       = ir_q;
  assign bus.pc_o       = pc_q;
  assign bus.ir_valid_o = ir_valid_q;
  assign bus.fault_o    = fault_q;

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the
    // case statement leaves one unassigned and infers a latch.
    state_d    = state_q;
    addr_d     = addr_q;
    pend_d     = pend_q;
    pend_pc_d  = pend_pc_q;
    tmo_cnt_d  = tmo_cnt_q;
    ir_d       = ir_q;
    pc_d       = pc_q;
    ir_valid_d = ir_valid_q;
    fault_d    = fault_q;

    unique case (state_q)
      IDLE: begin
        if (bus.pc_load_i) begin
          addr_d  = bus.pc_wd_i;
          state_d = REQ;
        end
      end

      REQ: begin
        // A load during a fetch is parked; the in-flight read still completes.
        if (bus.pc_load_i) begin
          pend_d    = 1'b1;
          pend_pc_d = bus.pc_wd_i;
        end
        if (misaligned) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end else if (bus.mem_ready_i) begin
          ir_d       = bus.mem_data_i;
          pc_d       = addr_q;
          ir_valid_d = 1'b1;
          tmo_cnt_d  = '0;
          state_d    = HOLD;
        end else if (tmo_cnt_q == TMO_LAST) begin
          tmo_cnt_d = '0;
          fault_d   = 1'b1;
          state_d   = FAULT;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end

      HOLD: begin
        if (bus.ir_ack_i) begin
          ir_valid_d = 1'b0;
          if (bus.pc_load_i) begin
            addr_d  = bus.pc_wd_i;
            pend_d  = 1'b0;
            state_d = REQ;
          end else if (pend_q) begin
            addr_d  = pend_pc_q;
            pend_d  = 1'b0;
            state_d = REQ;
          end else begin
            state_d = IDLE;
          end
        end else if (bus.pc_load_i) begin
          pend_d    = 1'b1;
          pend_pc_d = bus.pc_wd_i;
        end
      end

      FAULT: begin
        pend_d = 1'b0;
        if (bus.pc_load_i) begin
          addr_d  = bus.pc_wd_i;
          fault_d = 1'b0;
          state_d = REQ;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; reset is synchronous and overrides the next-state logic.
    if (reset) begin
      state_q    <= REQ;
      addr_q     <= RESET_PC;
      pend_q     <= 1'b0;
      pend_pc_q  <= '0;
      tmo_cnt_q  <= '0;
      ir_q       <= '0;
      pc_q       <= '0;
      ir_valid_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
      tmo_cnt_q  <= tmo_cnt_d;
      ir_q       <= ir_d;
      pc_q       <= pc_d;
      ir_valid_q <= ir_valid_d;
      fault_q    <= fault_d;
    end
  end

endmodule
